// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
package pipe_adder_pkg;

  localparam int PIPE_ADD_WIDTH = 16;
  localparam int PIPE_ADD_CHUNK = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = PIPE_ADD_WIDTH,
  parameter int OCC_W =
    clog2(PIPE_ADD_WIDTH / PIPE_ADD_CHUNK + 1)
);

  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             c_in_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] sum_o;
  logic             c_out_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OCC_W-1:0] occupancy_o;

  modport master (
    output a_i, b_i, c_in_i,
    output in_valid_i, out_ready_i,
    input  in_ready_o, sum_o, c_out_o,
    input  out_valid_o, occupancy_o
  );

  modport slave (
    input  a_i, b_i, c_in_i,
    input  in_valid_i, out_ready_i,
    output in_ready_o, sum_o, c_out_o,
    output out_valid_o, occupancy_o
  );

endinterface

// File: rtl/pipe_adder_stage.sv
// One ripple slice: CHUNK-bit add with carry in and out.
module pipe_adder_stage #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out
);

  assign {carry_out, sum} =
    {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, carry_in};

endmodule

// File: rtl/pipe_adder.sv
// WIDTH-bit adder split into CHUNK-bit registered slices,
// valid/ready chained so bubbles collapse under back-pressure.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = PIPE_ADD_WIDTH,
  parameter int CHUNK = PIPE_ADD_CHUNK
) (
  input logic       clk_i,
  input logic       reset_i,
  pipe_adder_if.slave bus
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int OCC_W  = clog2(STAGES + 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("pipe_adder: WIDTH must be a multiple of CHUNK");
  end

  logic [STAGES:0]   ready;
  logic [STAGES-1:0] valid;
  logic [OCC_W-1:0]  occ;

  assign ready[STAGES] = bus.out_ready_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // REM: operand bits not yet added; LOW: sum bits done
    localparam int REM = WIDTH - k * CHUNK;
    localparam int LOW = (k + 1) * CHUNK;

    logic             valid_q;
    logic             carry_q;
    logic [LOW-1:0]   sum_q;
    logic [LOW-1:0]   nxt_sum;
    logic             src_valid;
    logic             src_carry;
    logic [REM-1:0]   src_a;
    logic [REM-1:0]   src_b;
    logic [CHUNK-1:0] s;
    logic             co;

    if (k == 0) begin : g_head
      assign src_valid = bus.in_valid_i;
      assign src_carry = bus.c_in_i;
      assign src_a     = bus.a_i;
      assign src_b     = bus.b_i;
      assign nxt_sum   = s;
    end else begin : g_body
      assign src_valid = g_stage[k-1].valid_q;
      assign src_carry = g_stage[k-1].carry_q;
      assign src_a     = g_stage[k-1].g_keep.a_q;
      assign src_b     = g_stage[k-1].g_keep.b_q;
      assign nxt_sum   = {s, g_stage[k-1].sum_q};
    end

    pipe_adder_stage #(.CHUNK(CHUNK)) u_add (
      .a         (src_a[CHUNK-1:0]),
      .b         (src_b[CHUNK-1:0]),
      .carry_in  (src_carry),
      .sum       (s),
      .carry_out (co)
    );

    assign ready[k] = !valid_q || ready[k+1];
    assign valid[k] = valid_q;

    // data only moves with a valid item, so idle inputs never leak in
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (ready[k]) begin
        valid_q <= src_valid;
        if (src_valid) begin
          carry_q <= co;
          sum_q   <= nxt_sum;
        end
      end
    end

    if (REM > CHUNK) begin : g_keep
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_q;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ready[k] && src_valid) begin
          a_q <= src_a[REM-1:CHUNK];
          b_q <= src_b[REM-1:CHUNK];
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + OCC_W'(valid[k]);
    end
  end

  assign bus.in_ready_o  = ready[0];
  assign bus.out_valid_o = valid[STAGES-1];
  assign bus.sum_o       = g_stage[STAGES-1].sum_q;
  assign bus.c_out_o     = g_stage[STAGES-1].carry_q;
  assign bus.occupancy_o = occ;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder in three geometries.
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(16), .OCC_W(clog2(5))) b16 ();
  pipe_adder_if #(.WIDTH(8),  .OCC_W(clog2(2))) b8 ();
  pipe_adder_if #(.WIDTH(32), .OCC_W(clog2(5))) b32 ();

  pipe_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk_i(clk), .reset_i(rst), .bus(b16)
  );
  pipe_adder #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk_i(clk), .reset_i(rst), .bus(b8)
  );
  pipe_adder #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk_i(clk), .reset_i(rst), .bus(b32)
  );

  logic [16:0] q16 [$];
  logic [32:0] q32 [$];

  function automatic logic [16:0] ref16(
    input logic [15:0] a, input logic [15:0] b,
    input logic ci);
    return {1'b0, a} + {1'b0, b} + 17'(ci);
  endfunction

  function automatic logic [32:0] ref32(
    input logic [31:0] a, input logic [31:0] b,
    input logic ci);
    return {1'b0, a} + {1'b0, b} + 33'(ci);
  endfunction

  task automatic idle_all();
    b16.in_valid_i = 0; b16.a_i = '0; b16.b_i = '0;
    b16.c_in_i = 0; b16.out_ready_i = 0;
    b8.in_valid_i = 0; b8.a_i = '0; b8.b_i = '0;
    b8.c_in_i = 0; b8.out_ready_i = 0;
    b32.in_valid_i = 0; b32.a_i = '0; b32.b_i = '0;
    b32.c_in_i = 0; b32.out_ready_i = 0;
  endtask

  task automatic step16(
    input logic v, input logic [15:0] a,
    input logic [15:0] b, input logic ci,
    input logic rdy, output logic xin, output logic xout);
    @(negedge clk);
    b16.in_valid_i = v; b16.a_i = a; b16.b_i = b;
    b16.c_in_i = ci; b16.out_ready_i = rdy;
    #1;
    xin  = v && b16.in_ready_o;
    xout = b16.out_valid_o && rdy;
  endtask

  task automatic step8(
    input logic v, input logic [7:0] a,
    input logic [7:0] b, input logic ci,
    input logic rdy, output logic xin);
    @(negedge clk);
    b8.in_valid_i = v; b8.a_i = a; b8.b_i = b;
    b8.c_in_i = ci; b8.out_ready_i = rdy;
    #1;
    xin = v && b8.in_ready_o;
  endtask

  task automatic step32(
    input logic v, input logic [31:0] a,
    input logic [31:0] b, input logic ci,
    input logic rdy, output logic xin, output logic xout);
    @(negedge clk);
    b32.in_valid_i = v; b32.a_i = a; b32.b_i = b;
    b32.c_in_i = ci; b32.out_ready_i = rdy;
    #1;
    xin  = v && b32.in_ready_o;
    xout = b32.out_valid_o && rdy;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (b16.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", b16.out_valid_o);
    end
    checks++;
    if (b16.occupancy_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_occ got %0d want 0", b16.occupancy_o);
    end
    checks++;
    if ({b16.c_out_o, b16.sum_o} !== 17'h0) begin
      errors++;
      $display("FAIL reset_sum got %h want 0",
               {b16.c_out_o, b16.sum_o});
    end
    checks++;
    if (b16.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", b16.in_ready_o);
    end
    checks++;
    if ({b8.out_valid_o, b32.out_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid_other got %b want 00",
               {b8.out_valid_o, b32.out_valid_o});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_overflow();
    logic xin, xout;
    int first, cnt;
    logic [16:0] got;
    first = -1; cnt = 0; got = '0;
    step16(1, 16'hFFFF, 16'h0001, 0, 1, xin, xout);
    checks++;
    if (xin !== 1'b1) begin
      errors++;
      $display("FAIL ovf_accept got %b want 1", xin);
    end
    for (int n = 1; n <= 8; n++) begin
      step16(0, '0, '0, 0, 1, xin, xout);
      if (b16.out_valid_o) begin
        cnt++;
        if (first < 0) begin
          first = n;
          got = {b16.c_out_o, b16.sum_o};
        end
      end
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL ovf_latency got %0d want 4", first);
    end
    checks++;
    if (cnt != 1) begin
      errors++;
      $display("FAIL ovf_valid_cycles got %0d want 1", cnt);
    end
    checks++;
    if (got !== 17'h10000) begin
      errors++;
      $display("FAIL ovf_result got %h want 10000", got);
    end
  endtask

  task automatic test_back_to_back();
    logic xin, xout, ci;
    logic [16:0] exp;
    int i, nout, first, gaps;
    i = 0; nout = 0; first = -1; gaps = 0;
    q16.delete();
    for (int cyc = 0; cyc < 300 && nout < 100; cyc++) begin
      ci = i[0];
      step16(i < 100, 16'(i), 16'(3 * i), ci, 1, xin, xout);
      if (nout > 0 && !b16.out_valid_o) gaps++;
      if (i < 100) begin
        checks++;
        if (b16.in_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready cyc %0d got 0 want 1", cyc);
        end
      end
      if (xin) begin
        q16.push_back(ref16(16'(i), 16'(3 * i), ci));
        i++;
      end
      if (xout) begin
        if (first < 0) first = cyc;
        exp = q16.pop_front();
        checks++;
        if ({b16.c_out_o, b16.sum_o} !== exp) begin
          errors++;
          $display("FAIL b2b_result #%0d got %h want %h",
                   nout, {b16.c_out_o, b16.sum_o}, exp);
        end
        nout++;
      end
    end
    checks++;
    if (nout != 100) begin
      errors++;
      $display("FAIL b2b_count got %0d want 100", nout);
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL b2b_gaps got %0d want 0", gaps);
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL b2b_first_cycle got %0d want 4", first);
    end
  endtask

  task automatic test_stall();
    logic xin, xout, rdy, ci, hold;
    logic [15:0] a, b;
    logic [16:0] exp, prev;
    int i, nout;
    i = 0; nout = 0; hold = 0; prev = '0;
    q16.delete();
    for (int cyc = 0; cyc < 300 && nout < 40; cyc++) begin
      rdy = !(cyc >= 6 && cyc <= 15);
      a = 16'($urandom); b = 16'($urandom);
      ci = 1'($urandom);
      step16(i < 40, a, b, ci, rdy, xin, xout);
      checks++;
      if (b16.occupancy_o !== 3'(q16.size())) begin
        errors++;
        $display("FAIL stall_occ cyc %0d got %0d want %0d",
                 cyc, b16.occupancy_o, q16.size());
      end
      if (hold) begin
        checks++;
        if (!b16.out_valid_o ||
            {b16.c_out_o, b16.sum_o} !== prev) begin
          errors++;
          $display("FAIL stall_hold cyc %0d got %b/%h want 1/%h",
                   cyc, b16.out_valid_o,
                   {b16.c_out_o, b16.sum_o}, prev);
        end
      end
      if (cyc == 10) begin
        checks++;
        if (b16.in_ready_o !== 1'b0 ||
            b16.occupancy_o !== 3'd4) begin
          errors++;
          $display("FAIL stall_full got rdy %b occ %0d want 0 4",
                   b16.in_ready_o, b16.occupancy_o);
        end
      end
      if (cyc == 16) begin
        checks++;
        if (b16.in_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL stall_release got %b want 1",
                   b16.in_ready_o);
        end
      end
      if (xin) begin
        q16.push_back(ref16(a, b, ci));
        i++;
      end
      if (xout) begin
        exp = q16.pop_front();
        checks++;
        if ({b16.c_out_o, b16.sum_o} !== exp) begin
          errors++;
          $display("FAIL stall_result #%0d got %h want %h",
                   nout, {b16.c_out_o, b16.sum_o}, exp);
        end
        nout++;
      end
      hold = b16.out_valid_o && !rdy;
      prev = {b16.c_out_o, b16.sum_o};
    end
    checks++;
    if (nout != 40 || q16.size() != 0) begin
      errors++;
      $display("FAIL stall_count got %0d left %0d want 40 0",
               nout, q16.size());
    end
  endtask

  task automatic test_reset_flight();
    logic xin, xout;
    int stale;
    stale = 0;
    for (int n = 0; n < 3; n++) begin
      step16(1, 16'h1234 + 16'(n), 16'h0F0F, 1, 0, xin, xout);
    end
    step16(0, '0, '0, 0, 0, xin, xout);
    checks++;
    if (b16.occupancy_o !== 3'd3) begin
      errors++;
      $display("FAIL flight_occ got %0d want 3", b16.occupancy_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (b16.out_valid_o !== 1'b0 || b16.occupancy_o !== 3'd0 ||
        b16.sum_o !== 16'h0 || b16.c_out_o !== 1'b0) begin
      errors++;
      $display("FAIL flight_reset got v%b o%0d s%h c%b want 0",
               b16.out_valid_o, b16.occupancy_o,
               b16.sum_o, b16.c_out_o);
    end
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step16(0, '0, '0, 0, 1, xin, xout);
      if (b16.out_valid_o) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL flight_stale got %0d want 0", stale);
    end
  endtask

  task automatic test_single_stage();
    logic xin;
    step8(1, 8'h80, 8'h80, 1, 1, xin);
    checks++;
    if (xin !== 1'b1) begin
      errors++;
      $display("FAIL one_accept got %b want 1", xin);
    end
    step8(0, '0, '0, 0, 1, xin);
    checks++;
    if (b8.out_valid_o !== 1'b1 ||
        {b8.c_out_o, b8.sum_o} !== 9'h101) begin
      errors++;
      $display("FAIL one_result got v%b %h want v1 101",
               b8.out_valid_o, {b8.c_out_o, b8.sum_o});
    end
    step8(0, '0, '0, 0, 1, xin);
    checks++;
    if (b8.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL one_drop got %b want 0", b8.out_valid_o);
    end
  endtask

  task automatic test_random();
    logic xin, xout, v, rdy, ci;
    logic [31:0] a, b;
    logic [32:0] exp;
    int nout;
    nout = 0;
    q32.delete();
    for (int cyc = 0; cyc < 60000 && nout < 10000; cyc++) begin
      v = 1'($urandom); rdy = 1'($urandom);
      a = $urandom; b = $urandom; ci = 1'($urandom);
      step32(v, a, b, ci, rdy, xin, xout);
      checks++;
      if (b32.occupancy_o !== 3'(q32.size())) begin
        errors++;
        $display("FAIL rnd_occ cyc %0d got %0d want %0d",
                 cyc, b32.occupancy_o, q32.size());
      end
      if (xin) q32.push_back(ref32(a, b, ci));
      if (xout) begin
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious got output want none");
        end else begin
          exp = q32.pop_front();
          if ({b32.c_out_o, b32.sum_o} !== exp) begin
            errors++;
            $display("FAIL rnd_result #%0d got %h want %h",
                     nout, {b32.c_out_o, b32.sum_o}, exp);
          end
        end
        nout++;
      end
    end
    checks++;
    if (nout != 10000) begin
      errors++;
      $display("FAIL rnd_count got %0d want 10000", nout);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    test_single_stage();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
